// File: rtl/id_exe_reg_if.sv
// ID->EXE bundle: decoded fields from ID in, registered EXE operands/controls out.
// Latency: none (wiring only); the register itself lives in id_exe_reg.
// Backpressure: i_freeze holds the register, i_flush squashes it to a bubble.
// Ports (signals):
//   i_freeze, i_flush, i_valid        stage control from hazard unit / branch logic
//   i_pc, i_exe_cmd, i_wb_en, i_mem_r_en, i_mem_w_en, i_is_imm, i_imm_signed, i_imm,
//   i_reg1, i_reg2, i_src1, i_src2, i_dest                 decoded ID fields
//   o_pc, o_exe_cmd, o_wb_en, o_mem_r_en, o_mem_w_en, o_valid, o_val1, o_val2,
//   o_st_val, o_src1, o_src2, o_dest, o_bubble_cnt         registered EXE fields
// Modports: slave = the pipeline register, master = the driver/observer (ID side).
interface id_exe_reg_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 i_freeze;
  logic                 i_flush;
  logic                 i_valid;
  logic [WIDTH-1:0]     i_pc;
  logic [3:0]           i_exe_cmd;
  logic                 i_wb_en;
  logic                 i_mem_r_en;
  logic                 i_mem_w_en;
  logic                 i_is_imm;
  logic                 i_imm_signed;
  logic [15:0]          i_imm;
  logic [WIDTH-1:0]     i_reg1;
  logic [WIDTH-1:0]     i_reg2;
  logic [4:0]           i_src1;
  logic [4:0]           i_src2;
  logic [4:0]           i_dest;

  logic [WIDTH-1:0]     o_pc;
  logic [3:0]           o_exe_cmd;
  logic                 o_wb_en;
  logic                 o_mem_r_en;
  logic                 o_mem_w_en;
  logic                 o_valid;
  logic [WIDTH-1:0]     o_val1;
  logic [WIDTH-1:0]     o_val2;
  logic [WIDTH-1:0]     o_st_val;
  logic [4:0]           o_src1;
  logic [4:0]           o_src2;
  logic [4:0]           o_dest;
  logic [CNT_WIDTH-1:0] o_bubble_cnt;

  modport slave (
    input  i_freeze, i_flush, i_valid, i_pc, i_exe_cmd, i_wb_en, i_mem_r_en,
           i_mem_w_en, i_is_imm, i_imm_signed, i_imm, i_reg1, i_reg2,
           i_src1, i_src2, i_dest,
    output o_pc, o_exe_cmd, o_wb_en, o_mem_r_en, o_mem_w_en, o_valid,
           o_val1, o_val2, o_st_val, o_src1, o_src2, o_dest, o_bubble_cnt
  );

  modport master (
    output i_freeze, i_flush, i_valid, i_pc, i_exe_cmd, i_wb_en, i_mem_r_en,
           i_mem_w_en, i_is_imm, i_imm_signed, i_imm, i_reg1, i_reg2,
           i_src1, i_src2, i_dest,
    input  o_pc, o_exe_cmd, o_wb_en, o_mem_r_en, o_mem_w_en, o_valid,
           o_val1, o_val2, o_st_val, o_src1, o_src2, o_dest, o_bubble_cnt
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with operand-2 select, stall, squash and a bubble counter.
// Latency: 1 cycle ID inputs -> EXE outputs; every output comes straight from a flop.
// Backpressure: freeze holds all state; flush (dominates freeze) loads a bubble.
// Ports:
//   i_clk   core clock, rising edge
//   i_rst   asynchronous active-high reset, clears every register
//   bus     id_exe_reg_if.slave: ID fields in, registered EXE fields and bubble count out
module id_exe_reg #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  id_exe_reg_if.slave   bus
);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [3:0]       exe_cmd;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             valid;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] st_val;
    logic [4:0]       src1;
    logic [4:0]       src2;
    logic [4:0]       dest;
  } exe_t;

  exe_t                 r_exe;
  exe_t                 w_exe_nxt;
  logic [CNT_WIDTH-1:0] r_bubble_cnt;

  logic                 w_load;
  logic                 w_bubble;
  logic [WIDTH-1:0]     w_imm_ext;

  // Flush overrides a stall, so the register updates whenever either is true.
  assign w_load   = bus.i_flush | ~bus.i_freeze;
  assign w_bubble = bus.i_flush | ~bus.i_valid;

  assign w_imm_ext = bus.i_imm_signed ? {{(WIDTH-16){bus.i_imm[15]}}, bus.i_imm}
                                      : {{(WIDTH-16){1'b0}}, bus.i_imm};

  // A bubble is all-zero: no write-back/memory enable and index 0, which the
  // forwarding/hazard logic never matches.
  always_comb begin
    w_exe_nxt = '0;
    if (!w_bubble) begin
      w_exe_nxt.pc       = bus.i_pc;
      w_exe_nxt.exe_cmd  = bus.i_exe_cmd;
      w_exe_nxt.wb_en    = bus.i_wb_en;
      w_exe_nxt.mem_r_en = bus.i_mem_r_en;
      w_exe_nxt.mem_w_en = bus.i_mem_w_en;
      w_exe_nxt.valid    = 1'b1;
      w_exe_nxt.val1     = bus.i_reg1;
      w_exe_nxt.val2     = bus.i_is_imm ? w_imm_ext : bus.i_reg2;
      w_exe_nxt.st_val   = bus.i_reg2;
      w_exe_nxt.src1     = bus.i_src1;
      w_exe_nxt.src2     = bus.i_src2;
      w_exe_nxt.dest     = bus.i_dest;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exe <= '0;
    end else if (w_load) begin
      r_exe <= w_exe_nxt;
    end
  end

  // Saturating: a long squash/stall storm must not wrap back to a small count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bubble_cnt <= '0;
    end else if (w_load && w_bubble && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.o_pc         = r_exe.pc;
  assign bus.o_exe_cmd    = r_exe.exe_cmd;
  assign bus.o_wb_en      = r_exe.wb_en;
  assign bus.o_mem_r_en   = r_exe.mem_r_en;
  assign bus.o_mem_w_en   = r_exe.mem_w_en;
  assign bus.o_valid      = r_exe.valid;
  assign bus.o_val1       = r_exe.val1;
  assign bus.o_val2       = r_exe.val2;
  assign bus.o_st_val     = r_exe.st_val;
  assign bus.o_src1       = r_exe.src1;
  assign bus.o_src2       = r_exe.src2;
  assign bus.o_dest       = r_exe.dest;
  assign bus.o_bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register of the five-stage MIPS core; sits directly upstream of the ALU and drives its in1/in2/cmd operands through the EXE-stage forwarding muxes.
- Captures decoded control, operand values and register indices from ID each cycle.
- Selects the second operand (register or extended immediate) before registering.
- Supports stall (freeze), squash (flush) and bubble insertion, and keeps a saturating bubble counter for performance debug.

Parameters:
- WIDTH, 32, datapath width of PC, operand and immediate outputs.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- freeze  input  1  hazard-unit stall; hold all registered state
- flush  input  1  branch-taken squash; load a bubble
- valid_in  input  1  ID holds a real instruction
- pc_in  input  WIDTH  PC+4 of the ID instruction
- exe_cmd_in  input  4  ALU command: 0000 add, 0010 sub, 0100 and, 0101 or, 0110 nor, 0111 xor, 1000 sll, 1010 srl, 1001 sra
- wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  write-back and memory controls
- is_imm_in  input  1  second operand is the immediate
- imm_signed_in  input  1  1 = sign-extend imm, 0 = zero-extend
- imm_in  input  16  raw immediate field
- reg1_in, reg2_in  input  WIDTH  register-file read data
- src1_in, src2_in, dest_in  input  5 each  register indices
- pc_out  output  WIDTH  registered PC
- exe_cmd_out  output  4  to ALU cmd
- wb_en_out, mem_r_en_out, mem_w_en_out, valid_out  output  1 each
- val1_out  output  WIDTH  operand 1 (reg1)
- val2_out  output  WIDTH  operand 2 (reg2 or extended imm)
- st_val_out  output  WIDTH  raw reg2, store data for SW
- src1_out, src2_out, dest_out  output  5 each  to forwarding and hazard units
- bubble_cnt  output  CNT_WIDTH  count of bubbles entered

Behaviour:
- Reset (rst=1, asynchronous, no clock needed): every output register is 0, bubble_cnt is 0. A reset asserted mid-stall or mid-flush discards all state.
- Per-edge priority is rst > flush > freeze > load.
- Flush: load a bubble; takes effect even when freeze=1.
- Freeze (flush=0): hold every output register, including valid_out; bubble_cnt unchanged.
- Load with valid_in=1: all fields captured.
  - val2 = is_imm_in ? ext(imm_in) : reg2_in.
  - ext = {16{imm[15]}, imm} when imm_signed_in=1, otherwise {16'b0, imm}.
  - st_val_out = reg2_in regardless of is_imm_in.
- Load with valid_in=0: treated as a bubble.
- Bubble contents: valid_out, wb_en_out, mem_r_en_out, mem_w_en_out = 0; exe_cmd_out = 0000; dest_out = 0; all other data and index fields = 0.
  - No write-back or memory side effect can escape from a bubble.
  - Indices of 0 never match a forwarding compare, because $0 is excluded downstream.
- Bubble counter:
  - Increments on every edge where a bubble is loaded (flush=1, or freeze=0 with valid_in=0).
  - Saturates at all-ones and never wraps.
  - Does not increment while frozen without flush.
- Latency: exactly 1 cycle from ID inputs to outputs; no combinational input-to-output path.
- Control inputs are sampled only at clock edges; glitches between edges have no effect.
- Shift commands carry the shift amount in val2_out unchanged; this block does not interpret exe_cmd.

Test Plan:
- Reset then load: rst pulse mid-cycle → outputs 0 immediately; next edge with valid_in=1, exe_cmd_in=0010, reg1=0x0000_0009, reg2=0x0000_0004, is_imm=0 → val1_out=9, val2_out=4, exe_cmd_out=0010, valid_out=1 after 1 cycle.
- Immediate extension: imm_in=0xFFF0 with is_imm=1, signed=1 → val2_out=0xFFFF_FFF0; signed=0 → val2_out=0x0000_FFF0; st_val_out equals reg2_in in both cases.
- Freeze hold: load an ADD, then freeze=1 for 3 cycles while inputs change → outputs constant for all 3 cycles; bubble_cnt unchanged; release → new inputs appear on the next edge.
- Flush beats freeze: freeze=1, flush=1, valid_in=1 with wb_en_in=1, mem_w_en_in=1 → wb_en_out=0, mem_w_en_out=0, valid_out=0, exe_cmd_out=0000, dest_out=0, bubble_cnt increments by 1.
- Invalid load: valid_in=0 with mem_r_en_in=1, dest_in=5 → mem_r_en_out=0, dest_out=0, bubble_cnt increments by 1.
- Counter saturation: CNT_WIDTH=4, apply 20 consecutive flushes → bubble_cnt reaches 15 and stays at 15; rst → bubble_cnt=0 asynchronously.
